execute_stage_param: RTL and testbench
======================================

// Module: execute_stage_param
// PURPOSE
//  Parametrised execute stage for the pipelined processor: operand select, ALU, a registered
//  Z/N/C flag register and conditional-branch resolution. It adds a multi-cycle shift-add
//  multiplier and a valid/ready handshake to the decode and memory stages, so the stage can
//  stall the pipeline. Sits between the ID/EX and EX/MEM pipeline registers.
// PARAMETERS
//  WIDTH   16  datapath width (>=4); shift amount taken from B[$clog2(WIDTH)-1:0]
//  MUL_EN  1   1: func 111 is MUL; 0: func 111 acts as NOP (pass A, no flag update)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-low reset
//  inValid      in   1      decode offers an instruction
//  inReady      out  1      stage accepts this cycle (handshake = inValid & inReady)
//  aluOp        in   1      1: ALU op per func; 0: pass readData1, flags untouched
//  aluSrc       in   1      operand B = aluSrc ? immediate : readData2
//  branch       in   1      branch instruction; func selects the condition
//  func         in   3      op/condition code
//  readData1    in   WIDTH  operand A / branch target
//  readData2    in   WIDTH  register operand B
//  immediate    in   WIDTH  immediate operand B
//  outValid     out  1      aluResult/branchTaken valid for memory stage
//  outReady     in   1      memory stage accepts the result
//  aluResult    out  WIDTH  registered result
//  flags        out  3      registered {C,N,Z}: [0]=Z [1]=N [2]=C
//  branchTaken  out  1      registered branch decision, valid with outValid
// BEHAVIOUR
//  - Reset (rst=0 at an edge): aluResult=0, flags=000, outValid=0, branchTaken=0, FSM=IDLE.
//    inReady=0 while rst=0. Reset mid-MUL aborts it; the partial product is discarded.
//  - inReady = (state==IDLE) & (~outValid | outReady) & rst. Output regs hold stable while
//    outValid & ~outReady. outValid drops after a handshake edge unless a new result loads.
//  - FSM: IDLE -> (accepted MUL, MUL_EN=1) -> MUL; MUL counts WIDTH cycles -> IDLE and loads the
//    output. Every other op loads the output at the accept edge: latency 1. MUL latency is WIDTH+1.
//  - ALU (aluOp=1, branch=0): 000 pass A; 001 A+B, C=carry out; 010 A-B, C=borrow (A<B);
//    011 A&B, C=0; 100 A|B, C=0; 101 ~A, C=0; 110 A<<shamt, C=last bit out (0 if shamt=0);
//    111 MUL low WIDTH bits of A*B, C=1 iff the high half is nonzero.
//    Z=(result==0), N=result[WIDTH-1]. Flags update at the output-load edge for ops 001-111.
//  - Branch (branch=1): aluResult=readData1. Condition from registered flags at the accept edge:
//    000 always, 001 JZ, 010 JN, 011 JC, others never. A taken JZ/JN/JC clears the tested flag.
//    Branch outValid/latency is the same as a 1-cycle op.
//  - aluOp=0, branch=0: aluResult=readData1, branchTaken=0, flags unchanged.
//  - Back-to-back: the flags written by op N are visible to the branch accepted at the
//    following edge (no bypass needed; both updates are registered).
//  - Width rule: all arithmetic mod 2^WIDTH; carry/borrow is computed in WIDTH+1 bits.
// TESTING (WIDTH=16, MUL_EN=1)
//  1 rst=0 for 2 cycles -> aluResult=0x0000, flags=000, outValid=0, inReady=0; rst=1 -> inReady=1
//  2 ADD A=0x0000 B=0x0001 aluSrc=0 -> next cycle aluResult=0x0001, flags=000, outValid=1
//  3 ADD 0xFFFF+imm 0x0001 (aluSrc=1) -> 0x0000, flags Z=1 C=1 N=0; then JZ -> branchTaken=1, Z=0
//  4 SUB 0x0003-0x0005 -> 0xFFFE, N=1 C=1 Z=0; outReady=0 for 3 cycles -> outputs stable, inReady=0
//  5 MUL 0x0003*0x0005 -> inReady=0 for 16 cycles, aluResult=0x000F at cycle 17, C=0
//  6 rst=0 at MUL cycle 8 -> next edge: IDLE, outValid=0, flags=000; a new ADD then completes normally

Source files
------------

// File: rtl/execute_stage_param.sv
// Execute stage: operand select, ALU with registered {C,N,Z} flags, branch resolution,
// a shift-add multiplier and valid/ready handshakes on both sides.
module execute_stage_param #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic             aluOp,
  input  logic             aluSrc,
  input  logic             branch,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  input  logic [WIDTH-1:0] immediate,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] aluResult,
  output logic [2:0]       flags,
  output logic             branchTaken
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [2:0]         flags_reg;
  logic               valid_reg;
  logic               taken_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [SW-1:0]      count_reg;

  logic [WIDTH-1:0]   op_b;
  logic [WIDTH:0]     wide;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               flag_upd;
  logic               cond;
  logic               accept;
  logic               mul_start;
  logic [2*WIDTH-1:0] acc_next;

  assign inReady   = (state_reg == IDLE) & (~valid_reg | outReady) & rst;
  assign accept    = inValid & inReady;
  assign mul_start = MUL_EN & aluOp & ~branch & (func == 3'b111);
  assign acc_next  = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;

  assign outValid    = valid_reg;
  assign aluResult   = result_reg;
  assign flags       = flags_reg;
  assign branchTaken = taken_reg;

  // Carry/borrow and the last shifted-out bit all land in wide[WIDTH].
  always_comb begin
    op_b     = aluSrc ? immediate : readData2;
    wide     = '0;
    alu_res  = readData1;
    alu_c    = 1'b0;
    flag_upd = 1'b0;
    if (aluOp) begin
      case (func)
        3'b001: begin
          wide     = {1'b0, readData1} + {1'b0, op_b};
          alu_res  = wide[WIDTH-1:0];
          alu_c    = wide[WIDTH];
          flag_upd = 1'b1;
        end
        3'b010: begin
          wide     = {1'b0, readData1} - {1'b0, op_b};
          alu_res  = wide[WIDTH-1:0];
          alu_c    = wide[WIDTH];
          flag_upd = 1'b1;
        end
        3'b011: begin alu_res = readData1 & op_b; flag_upd = 1'b1; end
        3'b100: begin alu_res = readData1 | op_b; flag_upd = 1'b1; end
        3'b101: begin alu_res = ~readData1;       flag_upd = 1'b1; end
        3'b110: begin
          wide     = {1'b0, readData1} << op_b[SW-1:0];
          alu_res  = wide[WIDTH-1:0];
          alu_c    = wide[WIDTH];
          flag_upd = 1'b1;
        end
        default: alu_res = readData1;
      endcase
    end
  end

  always_comb begin
    case (func)
      3'b000:  cond = 1'b1;
      3'b001:  cond = flags_reg[0];
      3'b010:  cond = flags_reg[1];
      3'b011:  cond = flags_reg[2];
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      flags_reg  <= '0;
      valid_reg  <= 1'b0;
      taken_reg  <= 1'b0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (outReady) valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept && mul_start) begin
            state_reg  <= MUL;
            mcand_reg  <= {{WIDTH{1'b0}}, readData1};
            mplier_reg <= op_b;
            acc_reg    <= '0;
            count_reg  <= '0;
          end else if (accept) begin
            valid_reg <= 1'b1;
            if (branch) begin
              result_reg <= readData1;
              taken_reg  <= cond;
              // A taken conditional branch consumes the flag it tested.
              if (cond && func != 3'b000) flags_reg[func[1:0] - 2'd1] <= 1'b0;
            end else begin
              result_reg <= alu_res;
              taken_reg  <= 1'b0;
              if (flag_upd)
                flags_reg <= {alu_c, alu_res[WIDTH-1], alu_res == '0};
            end
          end
        end
        MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            state_reg  <= IDLE;
            valid_reg  <= 1'b1;
            taken_reg  <= 1'b0;
            result_reg <= acc_next[WIDTH-1:0];
            flags_reg  <= {|acc_next[2*WIDTH-1:WIDTH], acc_next[WIDTH-1],
                           acc_next[WIDTH-1:0] == '0};
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_stage_param.sv
// Scoreboard bench for execute_stage_param (WIDTH=16, MUL_EN=1): expected results are queued
// at the accept edge and a monitor pops them on every output handshake.
module tb_execute_stage_param;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic         aluOp = 1'b0;
  logic         aluSrc = 1'b0;
  logic         branch = 1'b0;
  logic [2:0]   func = 3'b000;
  logic [W-1:0] readData1 = '0;
  logic [W-1:0] readData2 = '0;
  logic [W-1:0] immediate = '0;
  logic         outValid;
  logic         outReady = 1'b1;
  logic [W-1:0] aluResult;
  logic [2:0]   flags;
  logic         branchTaken;

  typedef struct packed {
    logic [W-1:0] res;
    logic [2:0]   fl;
    logic         bt;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  execute_stage_param #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .aluOp(aluOp), .aluSrc(aluSrc), .branch(branch), .func(func),
    .readData1(readData1), .readData2(readData2), .immediate(immediate),
    .outValid(outValid), .outReady(outReady), .aluResult(aluResult),
    .flags(flags), .branchTaken(branchTaken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else
      $display("ok   %s: 0x%0h", name, act);
  endtask

  // Monitor: one comparison per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && outValid && outReady) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {12'h0, aluResult, flags, branchTaken}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("result{res,flags,bt}", {12'h0, aluResult, flags, branchTaken},
              {12'h0, e.res, e.fl, e.bt});
        end
      end
    end
  end

  // Drive one instruction and hold it until the accept edge has passed.
  task automatic issue(input logic op, input logic src, input logic br, input logic [2:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm);
    int n;
    aluOp = op; aluSrc = src; branch = br; func = f;
    readData1 = a; readData2 = b; immediate = imm;
    inValid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (inReady) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic run(input string name, input logic op, input logic src, input logic br,
                     input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] imm, input logic [W-1:0] er, input logic [2:0] ef,
                     input logic ebt, input int lat);
    int n;
    int stall;
    exp_t e;
    issue(op, src, br, f, a, b, imm);
    e.res = er; e.fl = ef; e.bt = ebt;
    sb.push_back(e);
    n = 0;
    stall = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (outValid) break;
      if (!inReady) stall++;
    end
    chk({name, "_latency"}, n, lat);
    if (lat > 1) chk({name, "_inready_low_cycles"}, stall, lat - 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_aluResult", aluResult, 0);
    chk("rst_flags", flags, 0);
    chk("rst_outValid", outValid, 0);
    chk("rst_inReady", inReady, 0);
    rst = 1'b1;
    #1;
    chk("inReady_after_rst", inReady, 1);
    @(posedge clk); #1;

    run("add_0_1",   1, 0, 0, 3'b001, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 3'b000, 0, 1);
    run("add_carry", 1, 1, 0, 3'b001, 16'hFFFF, 16'h7777, 16'h0001, 16'h0000, 3'b101, 0, 1);
    run("jz_taken",  1, 0, 1, 3'b001, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 3'b100, 1, 1);

    // SUB with a three-cycle downstream stall
    outReady = 1'b0;
    run("sub_borrow", 1, 0, 0, 3'b010, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 3'b110, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_aluResult", aluResult, 16'hFFFE);
      chk("stall_outValid", outValid, 1);
      chk("stall_inReady", inReady, 0);
    end
    @(posedge clk); #1;
    outReady = 1'b1;

    run("jn_taken",  1, 0, 1, 3'b010, 16'h00AA, 16'h0, 16'h0, 16'h00AA, 3'b100, 1, 1);
    run("jc_taken",  1, 0, 1, 3'b011, 16'h00BB, 16'h0, 16'h0, 16'h00BB, 3'b000, 1, 1);
    run("jz_not",    1, 0, 1, 3'b001, 16'h00CC, 16'h0, 16'h0, 16'h00CC, 3'b000, 0, 1);
    run("jmp",       1, 0, 1, 3'b000, 16'h00DD, 16'h0, 16'h0, 16'h00DD, 3'b000, 1, 1);
    run("and",       1, 0, 0, 3'b011, 16'hF0F0, 16'h0FF0, 16'h0, 16'h00F0, 3'b000, 0, 1);
    run("or_imm",    1, 1, 0, 3'b100, 16'h8000, 16'hFFFF, 16'h0001, 16'h8001, 3'b010, 0, 1);
    run("br_never",  1, 0, 1, 3'b100, 16'h0011, 16'h0, 16'h0, 16'h0011, 3'b010, 0, 1);
    run("not",       1, 0, 0, 3'b101, 16'hFFFF, 16'h0, 16'h0, 16'h0000, 3'b001, 0, 1);
    run("shl_1",     1, 0, 0, 3'b110, 16'h8001, 16'h0001, 16'h0, 16'h0002, 3'b100, 0, 1);
    run("shl_0",     1, 0, 0, 3'b110, 16'h8000, 16'h0010, 16'h0, 16'h8000, 3'b010, 0, 1);
    run("passthru",  0, 0, 0, 3'b001, 16'h5555, 16'h1111, 16'h0, 16'h5555, 3'b010, 0, 1);
    run("pass_f000", 1, 0, 0, 3'b000, 16'h0000, 16'h1111, 16'h0, 16'h0000, 3'b010, 0, 1);
    run("sub_zero",  1, 0, 0, 3'b010, 16'h0005, 16'h0005, 16'h0, 16'h0000, 3'b001, 0, 1);
    run("mul_3x5",   1, 0, 0, 3'b111, 16'h0003, 16'h0005, 16'h0, 16'h000F, 3'b000, 0, W + 1);
    run("mul_ovf",   1, 1, 0, 3'b111, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 3'b101, 0, W + 1);

    // Reset in the middle of a multiply
    issue(1, 0, 0, 3'b111, 16'h0007, 16'h0009, 16'h0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_inReady", inReady, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_outValid", outValid, 0);
    chk("rst_mid_flags", flags, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_inReady_idle", inReady, 1);
    @(posedge clk); #1;
    run("add_after_rst", 1, 0, 0, 3'b001, 16'h0002, 16'h0003, 16'h0, 16'h0005, 3'b000, 0, 1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
